// File: rtl/sample_sequencer.sv
// Stores perceptron training samples from a load stream and replays them as
// evenly spaced train strobes for a configurable number of epochs.
module sample_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SPACING = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [17:0]               in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic                      start,
  input  logic [7:0]                epochs,
  input  logic [17:0]               learning_rate_in,
  output logic [18*N-1:0]           x,
  output logic [47:0]               expected_y,
  output logic [17:0]               learning_rate,
  output logic                      train,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    sample_count,
  output logic                      load_err
);

  localparam int unsigned DW   = 18;
  localparam int unsigned YW   = 48;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WPS  = N + 1;
  localparam int unsigned WIW  = ($clog2(WPS) > 0) ? $clog2(WPS) : 1;
  localparam int unsigned MEMW = DEPTH * WPS;
  localparam int unsigned AW   = ($clog2(MEMW) > 0) ? $clog2(MEMW) : 1;
  localparam int unsigned PW   = CW + 8;
  localparam int unsigned SW   = (SPACING > 1) ? $clog2(SPACING) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} state_t;

  state_t            state, state_next;
  logic [WIW-1:0]    widx, widx_next;
  logic [CW-1:0]     count_next;
  logic              err_next, ready_next;
  logic [IW-1:0]     play_idx, idx_next, pres_sel;
  logic [PW-1:0]     pres_left, pres_next;
  logic [SW-1:0]     space_cnt, space_next;
  logic [18*N-1:0]   x_next;
  logic [YW-1:0]     ey_next;
  logic [DW-1:0]     lr_next, y_word;
  logic              train_next, busy_next, done_next;
  logic              wr_en, present, accept, full;
  logic [AW-1:0]     wr_addr, rd_base;

  logic [DW-1:0]     mem [MEMW];

  assign accept = in_valid && in_ready;
  assign full   = (sample_count == CW'(DEPTH));

  // Next-state, buffer write and playback presentation logic
  always_comb begin
    state_next = state;
    widx_next  = widx;
    count_next = sample_count;
    err_next   = load_err;
    idx_next   = play_idx;
    pres_next  = pres_left;
    space_next = space_cnt;
    x_next     = x;
    ey_next    = expected_y;
    lr_next    = learning_rate;
    train_next = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    present    = 1'b0;
    pres_sel   = '0;
    rd_base    = '0;
    y_word     = '0;

    case (state)
      IDLE: begin
        // A load word takes precedence over a simultaneous start
        if (accept) begin
          count_next = '0;
          err_next   = 1'b0;
          wr_en      = 1'b1;
          if (in_last) begin
            err_next  = 1'b1;
            widx_next = '0;
          end else begin
            widx_next  = WIW'(1);
            state_next = LOAD;
          end
        end else if (start && (sample_count != '0) && (epochs != '0)) begin
          state_next = PLAY;
          lr_next    = learning_rate_in;
          pres_next  = PW'(sample_count) * PW'(epochs) - PW'(1);
          present    = 1'b1;
          idx_next   = '0;
          space_next = SW'(SPACING - 1);
          busy_next  = 1'b1;
        end
      end

      LOAD: begin
        if (accept) begin
          if (full) begin
            err_next = 1'b1;
            if (in_last) begin
              widx_next  = '0;
              state_next = IDLE;
            end
          end else begin
            wr_en   = 1'b1;
            wr_addr = AW'(32'(sample_count) * WPS + 32'(widx));
            if (widx == WIW'(N)) begin
              count_next = sample_count + CW'(1);
              widx_next  = '0;
              if (in_last) state_next = IDLE;
            end else if (in_last) begin
              err_next   = 1'b1;
              widx_next  = '0;
              state_next = IDLE;
            end else begin
              widx_next = widx + WIW'(1);
            end
          end
        end
      end

      PLAY: begin
        busy_next = 1'b1;
        if (space_cnt == '0) begin
          if (pres_left == '0) begin
            state_next = FINISH;
            done_next  = 1'b1;
          end else begin
            pres_next  = pres_left - PW'(1);
            present    = 1'b1;
            pres_sel   = (CW'(play_idx) + CW'(1) == sample_count) ? '0 : play_idx + IW'(1);
            idx_next   = pres_sel;
            space_next = SW'(SPACING - 1);
          end
        end else begin
          space_next = space_cnt - SW'(1);
        end
      end

      FINISH: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    if (present) begin
      train_next = 1'b1;
      rd_base    = AW'(32'(pres_sel) * WPS);
      for (int i = 0; i < int'(N); i++) begin
        x_next[DW*i +: DW] = mem[rd_base + AW'(i)];
      end
      y_word  = mem[rd_base + AW'(N)];
      ey_next = {{(YW-DW){y_word[DW-1]}}, y_word};
    end

    ready_next = (state_next == IDLE) || (state_next == LOAD);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      widx          <= '0;
      sample_count  <= '0;
      load_err      <= 1'b0;
      in_ready      <= 1'b0;
      play_idx      <= '0;
      pres_left     <= '0;
      space_cnt     <= '0;
      x             <= '0;
      expected_y    <= '0;
      learning_rate <= '0;
      train         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      widx          <= widx_next;
      sample_count  <= count_next;
      load_err      <= err_next;
      in_ready      <= ready_next;
      play_idx      <= idx_next;
      pres_left     <= pres_next;
      space_cnt     <= space_next;
      x             <= x_next;
      expected_y    <= ey_next;
      learning_rate <= lr_next;
      train         <= train_next;
      busy          <= busy_next;
      done          <= done_next;
    end
  end

  // Sample buffer; contents become unreachable once sample_count is cleared
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: load/playback vectors, corner sequences and
// randomized rounds against a sample-level reference model.
module tb_sample_sequencer;

  localparam int N  = 2;
  localparam int DP = 4;
  localparam int SP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [17:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [7:0]  epochs = '0;
  logic [17:0] learning_rate_in = '0;
  logic [35:0] x;
  logic [47:0] expected_y;
  logic [17:0] learning_rate;
  logic        train, busy, done;
  logic [2:0]  sample_count;
  logic        load_err;

  sample_sequencer #(.N(N), .DEPTH(DP), .SPACING(SP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .start(start), .epochs(epochs),
    .learning_rate_in(learning_rate_in), .x(x), .expected_y(expected_y),
    .learning_rate(learning_rate), .train(train), .busy(busy), .done(done),
    .sample_count(sample_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored samples and currently presented values
  logic [17:0] wq[$];
  logic [17:0] m_x [DP][N];
  logic [17:0] m_y [DP];
  int          m_count = 0;
  bit          m_err = 0;
  logic [35:0] cur_x = '0;
  logic [47:0] cur_y = '0;
  logic [17:0] m_lr = '0;

  typedef struct {
    int nwords;
    int ep;
    int exp_count;
    bit exp_err;
    int exp_trains;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_load();
    logic [17:0] part[$];
    m_count = 0;
    m_err   = 0;
    foreach (wq[i]) begin
      if (m_count == DP) m_err = 1;
      else begin
        part.push_back(wq[i]);
        if (part.size() == N + 1) begin
          for (int j = 0; j < N; j++) m_x[m_count][j] = part[j];
          m_y[m_count] = part[N];
          m_count++;
          part.delete();
        end
      end
    end
    if (part.size() != 0) m_err = 1;
  endtask

  task automatic load_words();
    for (int i = 0; i < wq.size(); i++) begin
      @(posedge clk); #1;
      chk("load_ready", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      in_data  = wq[i];
      in_last  = (i == wq.size() - 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_load();
  endtask

  task automatic play(input int ep, input logic [17:0] lr, input bit flood, output int ntrain);
    bit honour;
    int total, done_off, win, k, s;
    bit e_train, e_busy;
    honour   = (m_count > 0) && (ep > 0);
    total    = honour ? m_count * ep : 0;
    done_off = honour ? total * SP + 1 : 0;
    win      = honour ? done_off + 3 : 8;
    ntrain   = 0;
    k        = 0;
    @(posedge clk); #1;
    start = 1'b1;
    epochs = 8'(ep);
    learning_rate_in = lr;
    if (honour) m_lr = lr;
    for (int o = 1; o <= win; o++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = flood && honour && (o <= done_off);
      in_data  = 18'($urandom);
      in_last  = 1'($urandom);
      e_train  = honour && ((o - 1) % SP == 0) && ((o - 1) / SP < total);
      e_busy   = honour && (o <= done_off);
      if (e_train) begin
        s     = k % m_count;
        cur_x = {m_x[s][1], m_x[s][0]};
        cur_y = {{30{m_y[s][17]}}, m_y[s]};
        k++;
      end
      chk("train", 64'(train), 64'(e_train));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(honour && (o == done_off)));
      chk("play_ready", 64'(in_ready), 64'(!e_busy));
      chk("x", 64'(x), 64'(cur_x));
      chk("expected_y", 64'(expected_y), 64'(cur_y));
      chk("learning_rate", 64'(learning_rate), 64'(m_lr));
      if (train) ntrain++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic spec_words();
    wq.delete();
    wq.push_back(18'd1); wq.push_back(18'd2); wq.push_back(18'd5);
    wq.push_back(18'd3); wq.push_back(18'd4); wq.push_back(-18'sd7);
  endtask

  task automatic load_and_check(input int exp_count, input bit exp_err);
    load_words();
    chk("sample_count", 64'(sample_count), 64'(exp_count));
    chk("load_err", 64'(load_err), 64'(exp_err));
  endtask

  vec_t vecs[8];
  int   nt;

  initial begin
    vecs[0] = '{6, 2, 2, 0, 4};
    vecs[1] = '{2, 1, 0, 1, 0};
    vecs[2] = '{15, 1, 4, 1, 4};
    vecs[3] = '{3, 3, 1, 0, 3};
    vecs[4] = '{4, 0, 1, 1, 0};
    vecs[5] = '{12, 1, 4, 0, 4};
    vecs[6] = '{13, 2, 4, 1, 8};
    vecs[7] = '{1, 2, 0, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 64'(x), 64'(0));
    chk("rst_y", 64'(expected_y), 64'(0));
    chk("rst_lr", 64'(learning_rate), 64'(0));
    chk("rst_train", 64'(train), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_count", 64'(sample_count), 64'(0));
    chk("rst_err", 64'(load_err), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(in_ready), 64'(1));

    // Load/playback vector table
    for (int v = 0; v < 8; v++) begin
      if (v == 0) spec_words();
      else begin
        wq.delete();
        for (int i = 0; i < vecs[v].nwords; i++) wq.push_back(18'($urandom));
      end
      load_and_check(vecs[v].exp_count, vecs[v].exp_err);
      play(vecs[v].ep, 18'($urandom), 1'b0, nt);
      chk("train_total", 64'(nt), 64'(vecs[v].exp_trains));
      if (v == 0) chk("final_y_neg7", 64'(expected_y), 64'(48'hFFFF_FFFF_FFF9));
    end

    // in_valid flood during playback, then replay of unchanged set
    spec_words();
    load_and_check(2, 0);
    play(1, 18'h155, 1'b1, nt);
    chk("flood_trains", 64'(nt), 64'(2));
    chk("flood_count", 64'(sample_count), 64'(2));
    chk("flood_err", 64'(load_err), 64'(0));
    play(2, 18'h2AA, 1'b0, nt);
    chk("replay_trains", 64'(nt), 64'(4));
    play(0, 18'h3, 1'b0, nt);
    chk("epochs0_trains", 64'(nt), 64'(0));

    // Maximum epoch count
    play(255, 18'h1, 1'b0, nt);
    chk("epochs255_trains", 64'(nt), 64'(510));

    // Reset in the cycle after the second train pulse
    @(posedge clk); #1;
    start = 1'b1; epochs = 8'd2; learning_rate_in = 18'h77;
    for (int o = 1; o <= 4; o++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (o == 1 || o == 4) chk("pre_rst_train", 64'(train), 64'(1));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_x", 64'(x), 64'(0));
    chk("arst_y", 64'(expected_y), 64'(0));
    chk("arst_lr", 64'(learning_rate), 64'(0));
    chk("arst_train", 64'(train), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_count", 64'(sample_count), 64'(0));
    chk("arst_err", 64'(load_err), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_done", 64'(done), 64'(0));
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_release", 64'(in_ready), 64'(1));
    chk("done_release", 64'(done), 64'(0));
    m_count = 0; m_err = 0; cur_x = '0; cur_y = '0; m_lr = '0;
    play(2, 18'h5, 1'b0, nt);
    chk("post_rst_trains", 64'(nt), 64'(0));

    // Randomized rounds against the model
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = int'($urandom_range(1, 14));
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back(18'($urandom));
      load_words();
      chk("rnd_count", 64'(sample_count), 64'(m_count));
      chk("rnd_err", 64'(load_err), 64'(m_err));
      play(int'($urandom_range(0, 3)), 18'($urandom), 1'($urandom), nt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of perceptron inputs per sample.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the maximum number of stored samples.
REQ-003 The block SHALL have parameter SPACING, default 16, legal range 1 or more, giving the number of cycles between train pulses.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, using these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  load word valid.
- in_data  in  18  signed load word.
- in_last  in  1  marks the final word of the sample set.
- in_ready  out  1  block accepts a load word.
- start  in  1  single-cycle request to begin training playback.
- epochs  in  8  number of passes over the stored set, sampled at start.
- learning_rate_in  in  18  learning rate, sampled at start.
- x  out  18*N  sample inputs; element i occupies bits [18i+17:18i].
- expected_y  out  48  expected output for the sample, sign-extended from 18 bits.
- learning_rate  out  18  latched learning rate.
- train  out  1  one-cycle strobe marking a presented training sample.
- busy  out  1  playback in progress.
- done  out  1  one-cycle strobe marking the end of playback.
- sample_count  out  5  number of complete samples stored; the width is clog2(DEPTH)+1.
- load_err  out  1  sticky load-error flag.

Function
REQ-005 The state machine SHALL have four states: IDLE, LOAD, PLAY and FINISH.
REQ-006 Each sample SHALL consist of N+1 words, in this order: x[0]..x[N-1], then expected_y.
REQ-007 A word SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-008 The first word accepted in IDLE SHALL clear sample_count and load_err, write buffer slot 0 word 0, and move the state to LOAD.
REQ-009 In LOAD, the word index SHALL count from 0 to N, and sample_count SHALL increment when word N of a sample is accepted.
REQ-010 When in_last is accepted on word index N, the state SHALL return to IDLE.
REQ-011 When in_last is accepted on a word index other than N, the partial sample SHALL be discarded, load_err SHALL be set, and the state SHALL return to IDLE.
REQ-012 When sample_count equals DEPTH, in_ready SHALL still be high, but accepted words SHALL be dropped and load_err SHALL be set; in_last SHALL still return the state to IDLE.
REQ-013 in_ready SHALL be a registered output that is high in IDLE and LOAD and low in PLAY and FINISH.
REQ-014 start SHALL be honoured only in IDLE, only when sample_count > 0 and epochs > 0; in every other case start SHALL be ignored.
REQ-015 When start is honoured in cycle t, the block SHALL latch epochs and learning_rate_in and enter PLAY.
REQ-016 In PLAY, the block SHALL present samples in order 0..sample_count-1, wrapping to 0 at the end of each epoch.
REQ-017 The k-th presentation (k from 0) SHALL update x and expected_y and pulse train in cycle t+1+k*SPACING.
REQ-018 x and expected_y SHALL be registered and SHALL hold their values between presentations and after playback.
REQ-019 Exactly sample_count*epochs train pulses SHALL be issued per honoured start.
REQ-020 When SPACING=1, train SHALL stay high continuously and a new sample SHALL be presented every cycle.
REQ-021 SPACING cycles after the last train pulse, the state SHALL enter FINISH, done SHALL pulse for one cycle, and the next state SHALL be IDLE.
REQ-022 busy SHALL be high from cycle t+1 through the done cycle inclusive.
REQ-023 If in_valid is high during PLAY or FINISH, no word SHALL be accepted and the buffer SHALL be unchanged.
REQ-024 Buffer contents and sample_count SHALL persist across playbacks, so a second start replays the same set.
REQ-025 An epochs value of 255 SHALL be supported without counter overflow.

Reset
REQ-026 While rst is low, the state SHALL be IDLE and the following outputs SHALL be 0: x, expected_y, learning_rate, train, busy, done, sample_count, load_err and in_ready.
REQ-027 in_ready SHALL go high on the first clk edge after rst deasserts.
REQ-028 Reset asserted mid-LOAD or mid-PLAY SHALL abort the operation immediately and emit no done pulse.
REQ-029 Buffer RAM contents SHALL NOT be required to clear on reset, but sample_count=0 SHALL make them unreachable.

Verification
REQ-030 The bench SHALL use N=2, DEPTH=4, SPACING=3 and cover these scenarios:
- Load 2 samples, words {1,2,5},{3,4,-7}, with in_last on the 6th word -> sample_count=2 and load_err=0.
- Then start with epochs=2 -> train in cycles t+1, t+4, t+7, t+10; x sequence {1,2},{3,4},{1,2},{3,4}; expected_y=48'hFFFF_FFFF_FFF9 on the second and fourth presentations; done at t+13; busy from t+1 to t+13.
- in_last on the 2nd word of sample 1 -> load_err=1, sample_count=0, and a following start is ignored (busy stays 0).
- Load 5 samples into DEPTH=4 -> sample_count=4, load_err=1, and playback of epochs=1 issues 4 train pulses.
- rst asserted in the cycle after the 2nd train pulse -> all outputs 0 at once, no done pulse, and in_ready=1 one edge after release.
- start with epochs=0, or in_valid during PLAY -> start ignored and no words accepted, respectively; buffer and counters unchanged.
